serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial unsigned adder: sum = a + b, one bit per clock, LSB first.
//  Each bit uses a full-adder cell built from two half-adder stages.
//  Sits between operand-producing logic and result consumers; start/done handshake.
// PARAMETERS
//  WIDTH   8   operand and sum width in bits (>=2)
// PORTS
//  clk     in   1       rising-edge clock
//  rst_n   in   1       asynchronous active-low reset
//  start   in   1       request; sampled only in IDLE
//  a       in   WIDTH   operand A, captured on the accepted start edge
//  b       in   WIDTH   operand B, captured on the accepted start edge
//  busy    out  1       1 while in SHIFT
//  done    out  1       1-cycle pulse; sum/cout valid
//  sum     out  WIDTH   result, held until next accepted start
//  cout    out  1       carry out of bit WIDTH-1
//  ovf     out  1       signed overflow (only with SERIAL_ADD_OVF_EN)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0,
//   carry reg=0, bit counter=0, operand shift regs=0.
//  FSM IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: start=1 at edge k -> load a,b into shift regs; carry=0; cnt=0; SHIFT.
//   sum is not cleared on load, so the previous result stays readable.
//  SHIFT: each edge: s_i = a0^b0^carry; carry <= (a0&b0)|(carry&(a0^b0));
//   s_i shifted into sum MSB, sum shifts right; a,b regs shift right; cnt++.
//   After the edge processing bit WIDTH-1 (edge k+WIDTH): cout <= final carry,
//   state -> DONE.
//  DONE: done=1 for exactly one cycle; next edge -> IDLE.
//  Latency: done high in the cycle after edge k+WIDTH; throughput 1 op per WIDTH+2 cycles.
//  start while busy or in DONE: ignored; a and b are not re-sampled.
//  a/b changing after accept: no effect (the captured copy is used).
//  Reset mid-SHIFT: immediate abort; all outputs go to their reset values;
//   no done pulse for the aborted operation.
//  Arithmetic: modulo 2^WIDTH in sum; the bit-WIDTH carry goes to cout only.
//  Outputs are registered; no combinational path from start to any output.
// CONFIGURATION
//  SERIAL_ADD_OVF_EN defined:
//   - ovf <= carry_into_msb ^ carry_out_of_msb, updated with cout.
//   - Held until the next accepted start.
//  Undefined:
//   - ovf is tied to 0.
//   - No extra flops.
//   - The port remains present so the interface is fixed.
// STRUCTURE
//  Package serial_adder_pkg:
//   - state typedef {S_IDLE, S_SHIFT, S_DONE}
//   - localparam CNT_W = $clog2(WIDTH)
//  Sub-module fa_cell (a, b, cin -> s, co):
//   - two half-adder stages plus OR for the carry.
//   - Purely combinational.
//   - One instance; the top holds all the flops.
// TESTING (WIDTH=8; cycle counted from the edge that accepts start)
//  1. a=8'h5A, b=8'h3C, start for 1 cycle -> done 9th cycle, sum=8'h96, cout=0, busy 8 cycles.
//  2. a=8'hFF, b=8'h01 -> sum=8'h00, cout=1; with OVF_EN ovf=0.
//  3. a=8'h7F, b=8'h01 (OVF_EN) -> sum=8'h80, cout=0, ovf=1; without macro ovf=0.
//  4. Accept a=8'h10, b=8'h20; pulse start with a=8'hFF on cycle 3 -> ignored; sum=8'h30.
//  5. rst_n=0 on cycle 4 of SHIFT -> all outputs 0 immediately; no done; next op correct.
//  6. 1000 random a,b, back-to-back starts -> {cout,sum}==a+b; one done per accepted start.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional feature macro: SERIAL_ADD_OVF_EN (signed-overflow flag on ovf).
package serial_adder_pkg;

   // Controller states: wait for a request, shift one bit per clock, pulse done.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Operand width used when the top is instantiated without an override.
   localparam int WIDTH_DEFAULT = 8;

   // Bit-counter width for the default operand width.
   localparam int CNT_W = $clog2(WIDTH_DEFAULT);

   // Bit-counter width for an arbitrary operand width (never below one bit).
   function automatic int cnt_bits(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full adder built from two half-adder stages plus an OR for the
// carry. Purely combinational; the serial adder's top holds every flop.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);

   logic ha1_s;
   logic ha1_c;
   logic ha2_c;

   // First half adder combines the operand bits, second folds in the carry.
   always_comb begin
      ha1_s = a ^ b;
      ha1_c = a & b;
      s     = ha1_s ^ cin;
      ha2_c = ha1_s & cin;
      co    = ha1_c | ha2_c;
   end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: sum = a + b, one bit per clock, LSB first.
// Optional feature macro: SERIAL_ADD_OVF_EN -- when defined, ovf reports signed
// overflow of the last addition; otherwise ovf is tied low and costs no flops.
//
// Handshake: start is sampled only while idle; the rising edge that sees
// start=1 in IDLE accepts the request and captures a/b. busy is high for the
// WIDTH cycles of shifting, then done is high for exactly one cycle with
// sum/cout (and ovf) valid. start in any other state is ignored, and sum/cout
// hold their value until the next accepted request begins shifting.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CB = cnt_bits(WIDTH);
   localparam logic [CB-1:0] LAST_CNT = CB'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             carry;
   logic [CB-1:0]    cnt;
   logic             accept;
   logic             last_bit;
   logic             bit_s;
   logic             bit_co;

   // The one adder cell works on the current LSBs and the running carry.
   fa_cell u_fa (
      .a   (a_sr[0]),
      .b   (b_sr[0]),
      .cin (carry),
      .s   (bit_s),
      .co  (bit_co)
   );

   assign accept   = (state == S_IDLE) && start;
   assign last_bit = (state == S_SHIFT) && (cnt == LAST_CNT);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: IDLE -> SHIFT on request, SHIFT -> DONE after the MSB.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (start) state_nxt = S_SHIFT;
         S_SHIFT: if (cnt == LAST_CNT) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Status flags are registered copies of the upcoming state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_nxt == S_SHIFT);
         done <= (state_nxt == S_DONE);
      end
   end

   // Datapath: capture operands on accept, then shift one result bit per edge.
   // sum is not cleared on capture so the previous result stays readable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr  <= '0;
         b_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (accept) begin
         a_sr  <= a;
         b_sr  <= b;
         carry <= 1'b0;
         cnt   <= '0;
      end else if (state == S_SHIFT) begin
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         carry <= bit_co;
         cnt   <= cnt + CB'(1);
         sum   <= {bit_s, sum[WIDTH-1:1]};
         if (last_bit) cout <= bit_co;
      end
   end

`ifdef SERIAL_ADD_OVF_EN
   logic ovf_q;

   // Signed overflow: carry into the MSB differs from carry out of the MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        ovf_q <= 1'b0;
      else if (last_bit) ovf_q <= carry ^ bit_co;
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Randomized, self-checking bench for serial_adder (WIDTH=8).
// Results are predicted with plain integer arithmetic and queued; a monitor
// pops one expectation per done pulse.
module tb_serial_adder;

   localparam int W  = 8;
   localparam int EW = W + 2;   // {ovf, cout, sum}

`ifdef SERIAL_ADD_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int vectors     = 0;
   int miscompares = 0;
   int accepted    = 0;
   int done_cnt    = 0;

   logic [EW-1:0] exp_q[$];

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Unsigned sum with carry, plus signed overflow from the two's-complement range.
   function automatic logic [EW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
      int   total;
      int   sx;
      int   sy;
      int   st;
      logic o;
      total = int'(x) + int'(y);
      sx = (int'(x) >= (1 << (W - 1))) ? int'(x) - (1 << W) : int'(x);
      sy = (int'(y) >= (1 << (W - 1))) ? int'(y) - (1 << W) : int'(y);
      st = sx + sy;
      o  = OVF_EN && ((st > (1 << (W - 1)) - 1) || (st < -(1 << (W - 1))));
      return {o, total[W:0]};
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (rst_n === 1'b1 && done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            check("spurious_done", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("cout_sum", 64'({cout, sum}), 64'(e[W:0]));
            check("ovf", 64'(ovf), 64'(e[W+1]));
         end
      end
   end

   // ---------------- driver ----------------
   // One full operation: accept on the next edge, then WIDTH+1 cycles during
   // which busy/done timing is checked. Junk operands are driven after accept;
   // hold_start keeps start asserted, pulse_cyc asserts it once with a=FF.
   // Returns at the negedge of the done cycle.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit hold_start, input int pulse_cyc);
      int busy_cycles;
      busy_cycles = 0;
      @(negedge clk);
      a = av;
      b = bv;
      start = 1'b1;
      exp_q.push_back(model(av, bv));
      accepted++;
      @(posedge clk);
      for (int i = 1; i <= W + 1; i++) begin
         @(negedge clk);
         check("busy", 64'(busy), 64'(i <= W));
         check("done", 64'(done), 64'(i == W + 1));
         if (busy === 1'b1) busy_cycles++;
         start = hold_start || (i == pulse_cyc);
         a = (i == pulse_cyc) ? W'(8'hFF) : W'($urandom_range(0, (1 << W) - 1));
         b = W'($urandom_range(0, (1 << W) - 1));
      end
      check("busy_len", 64'(busy_cycles), 64'(W));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_sum",  64'(sum),  64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      check("rst_ovf",  64'(ovf),  64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: basic add, result held in idle
      run_op(8'h5A, 8'h3C, 1'b0, -1);
      start = 1'b0;
      check("t1_sum",  64'(sum),  64'h96);
      check("t1_cout", 64'(cout), 64'd0);
      @(negedge clk);
      check("t1_hold_sum", 64'(sum),  64'h96);
      check("t1_idle_done", 64'(done), 64'd0);

      // 2: unsigned wrap with carry out
      run_op(8'hFF, 8'h01, 1'b0, -1);
      start = 1'b0;
      check("t2_sum",  64'(sum),  64'h00);
      check("t2_cout", 64'(cout), 64'd1);
      check("t2_ovf",  64'(ovf),  64'd0);

      // 3: signed overflow without carry out
      run_op(8'h7F, 8'h01, 1'b0, -1);
      start = 1'b0;
      check("t3_sum",  64'(sum),  64'h80);
      check("t3_cout", 64'(cout), 64'd0);
      check("t3_ovf",  64'(ovf),  64'(OVF_EN));

      // 4: start pulse during shifting is ignored
      run_op(8'h10, 8'h20, 1'b0, 3);
      start = 1'b0;
      check("t4_sum", 64'(sum), 64'h30);

      // 5: reset in the 4th shift cycle aborts with no done
      @(negedge clk);
      a = 8'hC3;
      b = 8'h77;
      start = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_done", 64'(done), 64'd0);
      check("t5_sum",  64'(sum),  64'd0);
      check("t5_cout", 64'(cout), 64'd0);
      check("t5_ovf",  64'(ovf),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < W + 2; i++) begin
         @(negedge clk);
         check("t5_no_done", 64'(done), 64'd0);
      end
      run_op(8'hA5, 8'h5A, 1'b0, -1);
      start = 1'b0;
      check("t5_after_sum",  64'(sum),  64'hFF);
      check("t5_after_cout", 64'(cout), 64'd0);

      // 6: back-to-back random operations with start held high
      for (int n = 0; n < 1000; n++) begin
         case ($urandom_range(0, 15))
            0:       begin ra = '1; rb = '1; end
            1:       begin ra = '0; rb = '0; end
            2:       begin ra = 8'h80; rb = 8'h80; end
            default: begin
               ra = W'($urandom_range(0, (1 << W) - 1));
               rb = W'($urandom_range(0, (1 << W) - 1));
            end
         endcase
         run_op(ra, rb, 1'b1, -1);
      end
      start = 1'b0;
      repeat (W + 3) @(negedge clk);

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      check("done_count", 64'(done_cnt), 64'(accepted));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
